// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int data_width, input int digit_width);
    return data_width / digit_width;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// One digit of subtraction: a - b - bin, computed as a + ~b + ~bin.
module serial_sub_digit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~bin};
  assign diff = sum[WIDTH-1:0];
  // No carry out of the adder means the subtraction borrowed.
  assign bout = ~sum[WIDTH];

endmodule

// File: rtl/serial_sub.sv
// Digit-serial registered subtractor: Diff = A - B - Bin, one digit per cycle,
// with valid/ready handshakes on operand and result sides.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  InValid_SI,
  output logic                  InReady_SO,
  input  logic [DATA_WIDTH-1:0] A_DI,
  input  logic [DATA_WIDTH-1:0] B_DI,
  input  logic                  Bin_DI,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI,
  output logic [DATA_WIDTH-1:0] Diff_DO,
  output logic                  Bout_DO
);

  localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int CNT_W      = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  if ((DIGIT_WIDTH < 1) || ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_bad_width
    $error("serial_sub: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    borrow_reg;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [DIGIT_WIDTH-1:0]  result_reg [NUM_DIGITS];

  logic [DIGIT_WIDTH-1:0]  a_digits [NUM_DIGITS];
  logic [DIGIT_WIDTH-1:0]  b_digits [NUM_DIGITS];
  logic [DIGIT_WIDTH-1:0]  diff_digit;
  logic                    borrow_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
    assign a_digits[gi] = a_reg[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign b_digits[gi] = b_reg[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign Diff_DO[gi*DIGIT_WIDTH +: DIGIT_WIDTH] = result_reg[gi];
  end

  serial_sub_digit #(
    .WIDTH (DIGIT_WIDTH)
  ) u_digit (
    .a    (a_digits[cnt_reg]),
    .b    (b_digits[cnt_reg]),
    .bin  (borrow_reg),
    .diff (diff_digit),
    .bout (borrow_next)
  );

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) result_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (InValid_SI) begin
            a_reg      <= A_DI;
            b_reg      <= B_DI;
            borrow_reg <= Bin_DI;
            cnt_reg    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) result_reg[i] <= '0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          result_reg[cnt_reg] <= diff_digit;
          borrow_reg          <= borrow_next;
          if (cnt_reg == LAST_DIGIT) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (OutReady_SI) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake flags decode the state register only; borrow-out is the final running borrow.
  assign InReady_SO  = (state_reg == IDLE);
  assign OutValid_SO = (state_reg == DONE);
  assign Bout_DO     = borrow_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: reset, arithmetic cases, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
  logic        bout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub #(
    .DATA_WIDTH  (12),
    .DIGIT_WIDTH (4)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .InValid_SI  (in_valid),
    .InReady_SO  (in_ready),
    .A_DI        (a),
    .B_DI        (b),
    .Bin_DI      (bin),
    .OutValid_SO (out_valid),
    .OutReady_SI (out_ready),
    .Diff_DO     (diff),
    .Bout_DO     (bout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid is seen; lc = edges taken, or -1 on timeout.
  task automatic wait_valid(output int lc);
    lc = 0;
    while (!out_valid && lc < 20) begin
      step();
      lc++;
    end
    if (!out_valid) lc = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, in_ready, diff, bout} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b ready=%b diff=%h bout=%b, want 0 1 000 0",
               out_valid, in_ready, diff, bout);
    end else $display("reset_state ok");
  endtask

  task automatic test_basic();
    int cyc;
    int ready_bad;
    int lc;
    ready_bad = 0;
    a = 12'h123; b = 12'h023; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (in_ready !== 1'b0) ready_bad++;
      step();
      cyc++;
    end
    if (in_ready !== 1'b0) ready_bad++;
    lc = out_valid ? cyc : -1;
    n_cmp++;
    if (lc !== 4) begin
      n_bad++;
      $display("FAIL basic_latency: valid at cycle %0d, want 4", lc);
    end
    n_cmp++;
    if (ready_bad !== 0) begin
      n_bad++;
      $display("FAIL basic_ready_low: %0d cycles with ready high, want 0", ready_bad);
    end
    n_cmp++;
    if ({diff, bout} !== {12'h100, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: diff=%h bout=%b, want 100 0", diff, bout);
    end else $display("basic 123-023-0 = %h bout=%b", diff, bout);
    consume();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_return_idle: ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic run_case(input string name, input logic [11:0] va, input logic [11:0] vb,
                          input logic vbin, input logic [11:0] ediff, input logic ebout);
    int lc;
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lc);
    n_cmp++;
    if (lc < 0 || {diff, bout} !== {ediff, ebout}) begin
      n_bad++;
      $display("FAIL %s: diff=%h bout=%b lc=%0d, want %h %b", name, diff, bout, lc, ediff, ebout);
    end else $display("%s %h-%h-%b = %h bout=%b", name, va, vb, vbin, diff, bout);
    consume();
  endtask

  task automatic test_cross_borrow();
    run_case("cross_borrow", 12'h100, 12'h001, 1'b0, 12'h0FF, 1'b0);
  endtask

  task automatic test_underflow();
    run_case("underflow_a", 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1);
    run_case("underflow_b", 12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1);
  endtask

  task automatic test_backpressure();
    int lc;
    int held_bad;
    held_bad = 0;
    a = 12'h321; b = 12'h021; bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lc);
    // Expected result 0x321-0x021-1 = 0x2FF, no borrow.
    a = 12'h555; b = 12'h111; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, diff, bout} !== {1'b1, 1'b0, 12'h2FF, 1'b0}) held_bad++;
      step();
    end
    n_cmp++;
    if (lc < 0 || held_bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold: %0d bad cycles lc=%0d diff=%h, want 0 bad diff=2ff", held_bad, lc, diff);
    end else $display("bp_hold diff=%h held 5 cycles", diff);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept: ready=%b, want 0", in_ready);
    end
    wait_valid(lc);
    n_cmp++;
    if (lc !== 3 || {diff, bout} !== {12'h444, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_new_result: diff=%h bout=%b lc=%0d, want 444 0 lc=3", diff, bout, lc);
    end else $display("bp_new_result 555-111 = %h", diff);
    consume();
  endtask

  task automatic test_reset_mid();
    int lc;
    a = 12'hABC; b = 12'h123; bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, in_ready, diff, bout} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b ready=%b diff=%h bout=%b, want 0 1 000 0",
               out_valid, in_ready, diff, bout);
    end else $display("reset_mid cleared");
    a = 12'h010; b = 12'h001; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lc);
    n_cmp++;
    if (lc !== 3 || {diff, bout} !== {12'h00F, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_after: diff=%h bout=%b lc=%0d, want 00f 0 lc=3", diff, bout, lc);
    end else $display("reset_mid_after 010-001 = %h", diff);
    consume();
  endtask

  task automatic test_back_to_back();
    logic [11:0] va [8] = '{12'h123, 12'h000, 12'h800, 12'hFFF, 12'h0A5, 12'h7FF, 12'h001, 12'h456};
    logic [11:0] vb [8] = '{12'h023, 12'h000, 12'h801, 12'h000, 12'h5A0, 12'h7FF, 12'h002, 12'h123};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [12:0] exp_q [$];
    logic [12:0] e;
    int idx;
    int last_acc;
    int gap_bad;
    int n_acc;
    int n_res;
    int res_bad;
    int wide;
    idx = 0; last_acc = -1; gap_bad = 0; n_acc = 0; n_res = 0; res_bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = va[0]; b = vb[0]; bin = vc[0];
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (out_valid) begin
        n_res++;
        if (exp_q.size() == 0) res_bad++;
        else begin
          e = exp_q.pop_front();
          if ({bout, diff} !== e) begin
            res_bad++;
            $display("FAIL b2b_result: diff=%h bout=%b, want %h %b", diff, bout, e[11:0], e[12]);
          end else $display("b2b result diff=%h bout=%b", diff, bout);
        end
      end
      if (in_ready && idx < 8) begin
        wide = int'(a) - int'(b) - int'(bin);
        e[11:0] = 12'(wide);
        e[12] = (int'(a) < int'(b) + int'(bin));
        exp_q.push_back(e);
        if (last_acc >= 0 && cyc - last_acc != 5) gap_bad++;
        last_acc = cyc;
        n_acc++;
        step();
        idx++;
        if (idx < 8) begin
          a = va[idx]; b = vb[idx]; bin = vc[idx];
        end else in_valid = 1'b0;
      end else step();
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (gap_bad !== 0 || n_acc !== 8) begin
      n_bad++;
      $display("FAIL b2b_spacing: accepts=%0d bad_gaps=%0d, want 8 0", n_acc, gap_bad);
    end
    n_cmp++;
    if (res_bad !== 0 || n_res !== 8) begin
      n_bad++;
      $display("FAIL b2b_results: results=%0d bad=%0d, want 8 0", n_res, res_bad);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_basic();
    test_cross_borrow();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
